// File: rtl/rom_seq_stream.sv
// rtl/rom_seq_stream.sv - parametrised code-table ROM with seek and burst streaming
//
// Entry at linear address A = row*COLS + col is {row, CODE[col]},
// CODE = 1,3,4,8,10,13,15 indexed by col.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_req_valid    request present
//   o_req_ready    request can be accepted (idle only)
//   i_req_addr     start linear address
//   i_req_len      burst beats minus one
//   o_out_valid    o_out_data holds a beat
//   i_out_ready    consumer accepts the beat
//   o_out_data     {row, CODE[col]}
//   o_out_last     final beat of the burst
//   o_err          one-cycle pulse for an out-of-range request
//   o_busy         block is not idle

module rom_seq_stream #(
   parameter int ROWS   = 4,
   parameter int COLS   = 7,
   parameter int ROW_W  = 2,
   parameter int ADDR_W = 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic [ADDR_W-1:0]   i_req_len,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [ROW_W+3:0]    o_out_data,
   output logic                o_out_last,
   output logic                o_err,
   output logic                o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEEK,
      S_STREAM
   } state_t;

   // One extra bit so a full 2^ADDR_W table depth is representable.
   localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(ROWS * COLS);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [2:0]        LAST_COL = 3'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

   function automatic logic [3:0] code_of(input logic [2:0] col);
      logic [3:0] c;
      case (col)
         3'd0:    c = 4'd1;
         3'd1:    c = 4'd3;
         3'd2:    c = 4'd4;
         3'd3:    c = 4'd8;
         3'd4:    c = 4'd10;
         3'd5:    c = 4'd13;
         3'd6:    c = 4'd15;
         default: c = 4'd0;
      endcase
      return c;
   endfunction

   state_t               r_state;
   logic [ADDR_W-1:0]    r_rem;
   logic [ROW_W-1:0]     r_row;
   logic [2:0]           r_col;
   logic [ADDR_W-1:0]    r_count;
   logic                 r_out_valid;
   logic [ROW_W+3:0]     r_out_data;
   logic                 r_out_last;
   logic                 r_err;
   logic                 r_busy;
   logic                 r_req_ready;

   logic                 w_bad_addr;
   logic                 w_col_wrap;
   logic [2:0]           w_nxt_col;
   logic [ROW_W-1:0]     w_nxt_row;
   logic [ADDR_W-1:0]    w_nxt_count;

   // Next table position after a transferred beat; the last entry wraps to 0.
   always_comb begin
      w_bad_addr  = ({1'b0, i_req_addr} >= DEPTH);
      w_col_wrap  = (r_col == LAST_COL);
      w_nxt_col   = w_col_wrap ? 3'd0 : r_col + 3'd1;
      w_nxt_row   = r_row;
      if (w_col_wrap) begin
         w_nxt_row = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end
      w_nxt_count = r_count - ADDR_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b1;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  if (w_bad_addr) begin
                     // Request is consumed; only the error pulse results.
                     r_err <= 1'b1;
                  end else begin
                     r_rem       <= i_req_addr;
                     r_row       <= '0;
                     r_count     <= i_req_len;
                     r_state     <= S_SEEK;
                     r_busy      <= 1'b1;
                     r_req_ready <= 1'b0;
                  end
               end
            end

            // Repeated subtraction replaces a divider: one row per cycle.
            S_SEEK: begin
               if (r_rem >= COLS_A) begin
                  r_rem <= r_rem - COLS_A;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col   <= 3'(r_rem);
                  r_state <= S_STREAM;
               end
            end

            S_STREAM: begin
               if (!r_out_valid) begin
                  // First beat is loaded one cycle after the seek settles.
                  r_out_valid <= 1'b1;
                  r_out_data  <= {r_row, code_of(r_col)};
                  r_out_last  <= (r_count == '0);
               end else if (i_out_ready) begin
                  if (r_count == '0) begin
                     r_state     <= S_IDLE;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_busy      <= 1'b0;
                     r_req_ready <= 1'b1;
                  end else begin
                     r_count    <= w_nxt_count;
                     r_col      <= w_nxt_col;
                     r_row      <= w_nxt_row;
                     r_out_data <= {w_nxt_row, code_of(w_nxt_col)};
                     r_out_last <= (w_nxt_count == '0);
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_err       = r_err;
   assign o_busy      = r_busy;

endmodule

// File: doc/rom_seq_stream.md
Name: rom_seq_stream

Overview:
- Parametrised successor to the team's fixed 28-entry code ROM.
- Entry at linear address A = row*COLS + col returns {row, CODE[col]}, with CODE = 1,3,4,8,10,13,15 (4-bit values) indexed by col.
- Adds a request handshake, a sequential address-to-row/column seek (no divider), a burst stream with valid/ready backpressure, table wrap-around and an out-of-range error flag.
- Sits between control logic and any consumer needing code sequences.

Parameters:
- ROWS, 4, number of table rows; 1..2^ROW_W.
- COLS, 7, entries per row; 1..7, uses CODE[0..COLS-1].
- ROW_W, 2, row field width; output width is ROW_W+4.
- ADDR_W, 5, width of req_addr and req_len; must satisfy ROWS*COLS <= 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  start linear address.
- req_len  in  ADDR_W  beats minus one (0 = 1 beat).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  ROW_W+4  {row, CODE[col]}.
- out_last  out  1  high with the final beat of a burst.
- err  out  1  one-cycle pulse on an out-of-range request.
- busy  out  1  high when not IDLE.

Behaviour:
- DEPTH = ROWS*COLS.
- Registers: state, row, rem/col, beats remaining, err.
- Reset (sync, highest priority, any state): state=IDLE; row=0, col=0, count=0; out_valid=0, out_last=0, err=0, busy=0; out_data=0. Reset mid-burst aborts it; no further beats are issued.
- IDLE:
  - req_ready=1.
  - On req_valid with req_addr >= DEPTH: err=1 for the next cycle only; stay in IDLE; request consumed.
  - On a valid req_addr: latch rem=req_addr, row=0, count=req_len; go to SEEK.
- SEEK, one step per cycle:
  - If rem >= COLS: rem -= COLS, row += 1.
  - Otherwise: col = rem, go to STREAM.
  - SEEK occupies floor(addr/COLS)+1 cycles. The first out_valid appears floor(addr/COLS)+2 cycles after the accepting edge.
- STREAM:
  - out_valid=1; out_data = {row, CODE[col]}, driven from registers only.
  - out_last = (count==0).
  - Beat transfers when out_valid && out_ready.
  - On transfer with count==0: go to IDLE, out_valid=0 the next cycle.
  - On transfer with count!=0: count -= 1 and advance:
    - col<COLS-1: col+1.
    - col==COLS-1, row<ROWS-1: col=0, row+1.
    - col==COLS-1, row==ROWS-1: col=0, row=0 (wrap to address 0).
  - With out_ready=0: out_data and out_last stay stable and no state changes.
- Bursts longer than DEPTH keep wrapping; no error.
- req_ready=0 outside IDLE. req_valid is ignored while busy. No queueing.
- Back-to-back: a new request can be accepted on the cycle after the last beat transfers (IDLE).
- CODE entries are zero-extended constants; the row field is truncated to ROW_W.

Test Plan:
- Reset, then req_addr=0, req_len=0 → SEEK 1 cycle; one beat out_data=6'h01 with out_last=1, out_valid 2 cycles after accept, then IDLE.
- req_addr=10, req_len=2, out_ready=1 → out_valid 3 cycles after accept; beats 6'h18, 6'h1A, 6'h1D; out_last only on 6'h1D.
- req_addr=26, req_len=3 → beats 6'h3D, 6'h3F, 6'h01, 6'h03 (wrap through address 0); out_last on 6'h03.
- req_addr=28 → err high exactly one cycle, no out_valid, req_ready stays 1; then req_addr=27, len=0 → single beat 6'h3F.
- req_addr=7, len=1, out_ready low 3 cycles on the first beat → 6'h11 held stable 3 cycles; then 6'h11, 6'h13 delivered once each.
- rst asserted during the second beat of a len=5 burst → next cycle out_valid=0, busy=0, req_ready=1, out_data=0; a fresh request afterwards starts cleanly.
